// File: rtl/drive_cmd_pkg.sv
// Shared types and constants for the drive command arbiter: one-hot drive
// commands, telemetry state codes, FSM states and the IR / UART key tables.
package drive_cmd_pkg;

    typedef enum logic [7:0] {
        CMD_IDLE  = 8'h00,
        CMD_FWD   = 8'h02,
        CMD_LEFT  = 8'h08,
        CMD_BRAKE = 8'h10,
        CMD_RIGHT = 8'h20,
        CMD_BACK  = 8'h80
    } drive_cmd_e;

    localparam logic [2:0] STAT_IDLE  = 3'b000;
    localparam logic [2:0] STAT_FWD   = 3'b001;
    localparam logic [2:0] STAT_LEFT  = 3'b010;
    localparam logic [2:0] STAT_BRAKE = 3'b011;
    localparam logic [2:0] STAT_RIGHT = 3'b100;
    localparam logic [2:0] STAT_BACK  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DRIVE   = 2'd1,
        S_BLOCKED = 2'd2
    } drive_state_e;

    localparam logic [11:0] IR_KEY_FWD   = 12'hD02;
    localparam logic [11:0] IR_KEY_LEFT  = 12'hB04;
    localparam logic [11:0] IR_KEY_BRAKE = 12'hA05;
    localparam logic [11:0] IR_KEY_RIGHT = 12'h906;
    localparam logic [11:0] IR_KEY_BACK  = 12'h708;

    localparam logic [7:0] UART_KEY_FWD   = 8'h77;  // 'w'
    localparam logic [7:0] UART_KEY_LEFT  = 8'h61;  // 'a'
    localparam logic [7:0] UART_KEY_BRAKE = 8'h20;  // space
    localparam logic [7:0] UART_KEY_RIGHT = 8'h64;  // 'd'
    localparam logic [7:0] UART_KEY_BACK  = 8'h73;  // 's'

    typedef struct packed {
        logic       hit;
        drive_cmd_e cmd;
    } key_decode_t;

    function automatic key_decode_t decode_ir_key(input logic [11:0] key);
        key_decode_t d;
        d.hit = 1'b1;
        d.cmd = CMD_IDLE;
        case (key)
            IR_KEY_FWD:   d.cmd = CMD_FWD;
            IR_KEY_LEFT:  d.cmd = CMD_LEFT;
            IR_KEY_BRAKE: d.cmd = CMD_BRAKE;
            IR_KEY_RIGHT: d.cmd = CMD_RIGHT;
            IR_KEY_BACK:  d.cmd = CMD_BACK;
            default:      d.hit = 1'b0;
        endcase
        return d;
    endfunction

    function automatic key_decode_t decode_uart_key(input logic [7:0] key);
        key_decode_t d;
        d.hit = 1'b1;
        d.cmd = CMD_IDLE;
        case (key)
            UART_KEY_FWD:   d.cmd = CMD_FWD;
            UART_KEY_LEFT:  d.cmd = CMD_LEFT;
            UART_KEY_BRAKE: d.cmd = CMD_BRAKE;
            UART_KEY_RIGHT: d.cmd = CMD_RIGHT;
            UART_KEY_BACK:  d.cmd = CMD_BACK;
            default:        d.hit = 1'b0;
        endcase
        return d;
    endfunction

    function automatic logic [2:0] cmd_to_stat(input drive_cmd_e c);
        logic [2:0] s;
        case (c)
            CMD_FWD:   s = STAT_FWD;
            CMD_LEFT:  s = STAT_LEFT;
            CMD_BRAKE: s = STAT_BRAKE;
            CMD_RIGHT: s = STAT_RIGHT;
            CMD_BACK:  s = STAT_BACK;
            default:   s = STAT_IDLE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/drive_cmd_arbiter_watchdog.sv
// Command watchdog: counts cycles since the last kick and saturates at
// TERMINAL; expired stays high until the next kick or reset.
module drive_watchdog #(
    parameter int unsigned TERMINAL = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic kick,
    output logic expired
);

    localparam int CNT_W = (TERMINAL < 2) ? 1 : $clog2(TERMINAL + 1);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TERMINAL);

    logic [CNT_W-1:0] count;

    // Free-running count since last kick, held at terminal value
    always_ff @(posedge clk) begin
        if (reset || kick) begin
            count <= '0;
        end else if (count != TERM) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == TERM);

endmodule

// File: rtl/drive_cmd_arbiter.sv
// Drive command arbiter: merges IR and UART keypresses into a one-hot motor
// command, blocks forward motion near obstacles (with hysteresis) and, when
// DRIVE_CMD_WATCHDOG_EN is defined, falls back to idle after a command
// silence of TIMEOUT_MS.
module drive_cmd_arbiter
    import drive_cmd_pkg::*;
#(
    parameter int         CLK_HZ     = 50_000_000,
    parameter int         TIMEOUT_MS = 500,
    parameter logic [3:0] PROX_STOP  = 4'd12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ir_valid,
    input  logic [31:0] ir_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [7:0]  rx_byte,
    input  logic [3:0]  prox_status,
    output logic [7:0]  cmd,
    output logic [2:0]  motor_stat,
    output logic        cmd_changed,
    output logic        timeout_flag
);

    localparam logic [3:0] PROX_RELEASE = PROX_STOP - 4'd2;
    localparam longint     WD_CYCLES_L  = (longint'(TIMEOUT_MS) * longint'(CLK_HZ)) / 64'sd1000;

    logic         ir_valid_q;
    logic         ir_event;
    logic         uart_event;
    key_decode_t  ir_key;
    key_decode_t  rx_key;
    logic         evt_valid;
    drive_cmd_e   evt_cmd;
    drive_state_e state;
    drive_state_e state_next;
    drive_cmd_e   latched;
    drive_cmd_e   latched_next;
    drive_cmd_e   cmd_next;
    logic         wd_expired;
    logic         timeout_fire;
    logic         prox_block;
    logic         prox_clear;
    logic         ir_unused;

    assign ir_unused  = ^{ir_data[31:28], ir_data[15:0]};
    assign rx_ready   = ~reset;
    assign ir_event   = ir_valid & ~ir_valid_q;
    assign uart_event = rx_valid & rx_ready;
    assign prox_block = (prox_status >= PROX_STOP);
    assign prox_clear = (prox_status < PROX_RELEASE);

    // Rising-edge detector for the IR data-ready level
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_valid_q <= 1'b0;
        end else begin
            ir_valid_q <= ir_valid;
        end
    end

    // Source arbitration: an IR event always wins and swallows the UART byte
    always_comb begin
        ir_key    = decode_ir_key(ir_data[27:16]);
        rx_key    = decode_uart_key(rx_byte);
        evt_valid = 1'b0;
        evt_cmd   = CMD_IDLE;
        if (ir_event) begin
            evt_valid = ir_key.hit;
            evt_cmd   = ir_key.cmd;
        end else if (uart_event) begin
            evt_valid = rx_key.hit;
            evt_cmd   = rx_key.cmd;
        end
    end

`ifdef DRIVE_CMD_WATCHDOG_EN
    localparam int unsigned WD_CYCLES = WD_CYCLES_L[31:0];

    drive_watchdog #(
        .TERMINAL(WD_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .kick   (evt_valid),
        .expired(wd_expired)
    );

    // Timeout flag rises when the watchdog forces idle, clears with the next command
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_flag <= 1'b0;
        end else if (evt_valid) begin
            timeout_flag <= 1'b0;
        end else if (timeout_fire) begin
            timeout_flag <= 1'b1;
        end
    end
`else
    logic cfg_unused;
    assign cfg_unused   = (WD_CYCLES_L == 64'sd0);
    assign wd_expired   = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    assign timeout_fire = wd_expired && !evt_valid && (state != S_IDLE);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            latched <= CMD_IDLE;
        end else begin
            state   <= state_next;
            latched <= latched_next;
        end
    end

    // FSM next-state: a new command decides first, then timeout, then proximity
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (evt_valid) begin
                    state_next = (evt_cmd == CMD_FWD && prox_block) ? S_BLOCKED : S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (evt_valid) begin
                    state_next = (evt_cmd == CMD_FWD && prox_block) ? S_BLOCKED : S_DRIVE;
                end else if (timeout_fire) begin
                    state_next = S_IDLE;
                end else if (latched == CMD_FWD && prox_block) begin
                    state_next = S_BLOCKED;
                end
            end
            S_BLOCKED: begin
                if (evt_valid) begin
                    state_next = (evt_cmd != CMD_FWD || prox_clear) ? S_DRIVE : S_BLOCKED;
                end else if (timeout_fire) begin
                    state_next = S_IDLE;
                end else if (prox_clear) begin
                    state_next = S_DRIVE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // FSM output decode: the command the motor will see next cycle
    always_comb begin
        latched_next = evt_valid ? evt_cmd : latched;
        case (state_next)
            S_DRIVE:   cmd_next = latched_next;
            S_BLOCKED: cmd_next = CMD_BRAKE;
            default:   cmd_next = CMD_IDLE;
        endcase
    end

    // Registered outputs with a one-cycle pulse whenever the command value moves
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd         <= CMD_IDLE;
            motor_stat  <= STAT_IDLE;
            cmd_changed <= 1'b0;
        end else begin
            cmd         <= cmd_next;
            motor_stat  <= cmd_to_stat(cmd_next);
            cmd_changed <= (cmd_next != cmd);
        end
    end

endmodule
